// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: from round key 10, emits round keys 10..0 one per
// valid/ready handshake so the inverse cipher needs no stored key table.
module aes_inv_key_sched #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] round_key_10,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         done
);

   if (NR != 10) begin : g_nr_check
      $error("aes_inv_key_sched: only NR=10 (AES-128) is supported");
   end

   typedef enum logic {IDLE, EMIT} state_e;

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic         done_q, done_d;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [127:0] row;
      row = '0;
      case (x[7:4])
         4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
         4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
         4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
         4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
         4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
         4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
         4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
         4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
         4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
         4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
         4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
         4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
         4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
         4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
         4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
         4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
         default: row = '0;
      endcase
      // Column 0 sits in the top byte of each row constant.
      return row[{~x[3:0], 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [31:0]  k0, k1, k2, k3, p3, rot, sub;
   logic [127:0] prev_key;

   // Undo one forward expansion step; p3 rebuilds w[i-1] of the previous round.
   always_comb begin
      {k0, k1, k2, k3} = key_q;
      p3  = k3 ^ k2;
      rot = {p3[23:0], p3[31:24]};
      sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      prev_key = {k0 ^ sub ^ {rcon(idx_q), 24'h0}, k1 ^ k0, k2 ^ k1, p3};
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = round_key_10;
               idx_d   = 4'd10;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (key_ready) begin
               if (idx_q == 4'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  key_d = prev_key;
                  idx_d = idx_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign key_valid = (state_q == EMIT);
   assign busy      = (state_q == EMIT);
   assign round_key = key_q;
   assign round_idx = idx_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: reference is a forward AES-128 key expansion with an
// S-box derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] round_key_10 = '0;
   logic         key_valid;
   logic         key_ready = 1'b0;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         busy;
   logic         done;

   aes_inv_key_sched #(.NR(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .round_key_10(round_key_10),
      .key_valid(key_valid), .key_ready(key_ready), .round_key(round_key),
      .round_idx(round_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] KAT10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] KAT9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
   localparam logic [127:0] KAT0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

   int           nt = 0;
   int           nf = 0;
   logic [7:0]   sb [256];
   logic [127:0] got [11];
   int           n_got;
   int           last_cyc;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   // Forward FIPS-197 expansion from the cipher key; returns round key r.
   function automatic logic [127:0] expand(input logic [127:0] k0, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // mode 0: ready held high; 1: random ready with a 5-cycle stall at idx 9;
   // 2: random ready plus a stray start at idx 6; 3: random ready.
   task automatic run_sched(input logic [127:0] k10, input int mode);
      int   stall9 = 0;
      int   cyc = 0;
      bit   pstall = 0, injected = 0, rdy;
      logic [127:0] pkey;
      logic [3:0]   pidx;
      n_got = 0;
      start = 1'b1;
      round_key_10 = k10;
      @(posedge clk); #1;
      start = 1'b0;
      round_key_10 = {4{$urandom}};
      nt++;
      if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== k10 || busy !== 1'b1 || done !== 1'b0) begin
         nf++;
         $display("FAIL start_latency: valid=%b idx=%0d key=%h busy=%b done=%b, want 1 10 %h 1 0",
                  key_valid, round_idx, round_key, busy, done, k10);
      end
      while (n_got < 11 && cyc < 300) begin
         start = 1'b0;
         nt++;
         if (key_valid !== 1'b1 || done !== 1'b0) begin
            nf++;
            $display("FAIL in_schedule: valid=%b done=%b, want 1 0", key_valid, done);
         end
         if (pstall) begin
            nt++;
            if (round_key !== pkey || round_idx !== pidx) begin
               nf++;
               $display("FAIL stall_hold: idx=%0d key=%h, want %0d %h", round_idx, round_key, pidx, pkey);
            end
         end
         case (mode)
            0: rdy = 1'b1;
            1: if (round_idx == 4'd9 && stall9 < 5) begin rdy = 1'b0; stall9++; end
               else rdy = 1'($urandom_range(0, 1));
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         if (mode == 2 && round_idx == 4'd6 && !injected) begin
            start = 1'b1;
            round_key_10 = {4{$urandom}};
            injected = 1'b1;
         end
         key_ready = rdy;
         if (rdy) begin
            nt++;
            if (round_idx !== 4'(10 - n_got)) begin
               nf++;
               $display("FAIL idx_order: idx=%0d, want %0d", round_idx, 10 - n_got);
            end
            got[n_got] = round_key;
            n_got++;
         end
         pstall = !rdy;
         pkey = round_key;
         pidx = round_idx;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      last_cyc = cyc;
      nt++;
      if (n_got < 11) begin
         nf++;
         $display("FAIL timeout: %0d keys transferred, want 11", n_got);
      end else if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0) begin
         nf++;
         $display("FAIL end_done: done=%b valid=%b busy=%b, want 1 0 0", done, key_valid, busy);
      end
   endtask

   task automatic check_against(input logic [127:0] k0, input string name);
      for (int n = 0; n < 11; n++) begin
         nt++;
         if (got[n] !== expand(k0, 10 - n)) begin
            nf++;
            $display("FAIL %s key%0d: got %h, want %h", name, 10 - n, got[n], expand(k0, 10 - n));
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nt++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd0 || round_key !== '0) begin
         nf++;
         $display("FAIL reset_state: valid=%b busy=%b done=%b idx=%0d key=%h, want all 0",
                  key_valid, busy, done, round_idx, round_key);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      run_sched(KAT10, 0);
      nt++;
      if (last_cyc !== 11) begin
         nf++;
         $display("FAIL back_to_back: %0d cycles for 11 keys, want 11", last_cyc);
      end
      nt++;
      if (got[1] !== KAT9 || got[10] !== KAT0) begin
         nf++;
         $display("FAIL kat: key9=%h key0=%h, want %h %h", got[1], got[10], KAT9, KAT0);
      end
      check_against(KAT0, "basic");
   endtask

   task automatic test_stall();
      run_sched(KAT10, 1);
      check_against(KAT0, "stall");
   endtask

   task automatic test_start_ignored();
      run_sched(KAT10, 2);
      check_against(KAT0, "start_ignored");
      repeat (3) begin
         @(posedge clk); #1;
         nt++;
         if (done !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            nf++;
            $display("FAIL single_done: done=%b busy=%b valid=%b, want 0 0 0", done, busy, key_valid);
         end
      end
   endtask

   task automatic test_mid_reset();
      int guard = 0;
      start = 1'b1;
      round_key_10 = KAT10;
      key_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (round_idx !== 4'd4 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      rst_n = 1'b0;
      #1;
      nt++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd0 || round_key !== '0) begin
         nf++;
         $display("FAIL mid_reset: valid=%b busy=%b done=%b idx=%0d key=%h, want all 0",
                  key_valid, busy, done, round_idx, round_key);
      end
      repeat (3) begin
         @(posedge clk); #1;
         nt++;
         if (done !== 1'b0) begin
            nf++;
            $display("FAIL mid_reset_no_done: done=%b, want 0", done);
         end
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_sched(128'h0, 0);
      nt++;
      if (got[10] !== expand(got[10], 0) || expand(got[10], 10) !== 128'h0) begin
         nf++;
         $display("FAIL zero_key: key0=%h expands to key10=%h, want 0", got[10], expand(got[10], 10));
      end
      check_against(got[10], "zero_key");
   endtask

   task automatic test_restart();
      logic [127:0] ka, kb;
      ka = {4{$urandom}};
      kb = {4{$urandom}};
      run_sched(ka, 0);
      run_sched(kb, 3);
      check_against(got[10], "restart");
      nt++;
      if (got[0] !== kb) begin
         nf++;
         $display("FAIL restart_key10: got %h, want %h", got[0], kb);
      end
   endtask

   task automatic test_random();
      logic [127:0] k;
      int bad = 0;
      for (int t = 0; t < 1000; t++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         run_sched(k, 3);
         for (int n = 0; n < 11; n++) begin
            nt++;
            if (got[n] !== expand(got[10], 10 - n) || (n == 0 && got[0] !== k)) begin
               nf++;
               if (bad < 10)
                  $display("FAIL random t=%0d key%0d: got %h, want %h", t, 10 - n, got[n], expand(got[10], 10 - n));
               bad++;
            end
         end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_basic();
      test_stall();
      test_start_ignored();
      test_mid_reset();
      test_restart();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Reverse-direction AES-128 key schedule for the decipher datapath.
- Takes the final round key (round key 10), such as the one the cipher path produces and the decipher path consumes.
- Regenerates round keys 9 down to 0 on the fly, one per accepted handshake, so the inverse-cipher rounds need no stored key table.
- Sits between the top-level key input and the decipher round logic.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported, any other value is a configuration error.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a schedule; sampled only in IDLE
- round_key_10  input  128  final round key; bits[127:96] = word w40, bits[31:0] = w43; sampled on accepted start
- key_valid  output  1  round_key / round_idx are valid
- key_ready  input  1  consumer accepts current key when key_valid & key_ready
- round_key  output  128  current round key, same word ordering as round_key_10
- round_idx  output  4  round number of round_key (10 down to 0)
- busy  output  1  high whenever FSM is not IDLE
- done  output  1  one-cycle pulse after round key 0 is accepted

Behaviour:
- Reset (async assert, synchronous-release usage assumed by top): FSM=IDLE; key_valid=0, busy=0, done=0, round_idx=0, round_key=0.
- FSM states: IDLE, EMIT.
- IDLE:
  - start=1 at edge N: round_key<=round_key_10, round_idx<=10, key_valid<=1, busy<=1, state<=EMIT.
  - Key 10 is visible in cycle N+1 (latency 1).
  - start=0: hold.
- EMIT, transfer (key_valid & key_ready) with round_idx>0: round_key<=prev(round_key), round_idx<=round_idx-1, key_valid stays 1. This gives back-to-back keys at one per cycle with key_ready held high.
- EMIT, transfer with round_idx==0: key_valid<=0, busy<=0, done<=1 for one cycle, state<=IDLE.
- EMIT, key_ready=0: round_key, round_idx and key_valid held stable (no change while stalled).
- start while in EMIT: ignored, with no effect on the in-flight schedule.
- start in the same cycle done is high: state is already IDLE, so it is accepted normally. Restart is possible on the cycle after the final transfer.
- prev(K), K = {k0,k1,k2,k3} (32-bit words, k0 MSB), r = round_idx:
  - p3 = k3 ^ k2
  - p2 = k2 ^ k1
  - p1 = k1 ^ k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
  - SubWord applies the forward AES S-box per byte: 4 combinational S-box instances (case ROM), in the single-cycle path.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; Rcon indexed by the current round_idx before decrement.
- All XOR is 32-bit bitwise; no carries, no width growth.
- round_idx never wraps below 0: the transfer at 0 terminates the schedule.
- Reset asserted mid-schedule: immediate return to reset values, and the partial schedule is discarded. No done pulse.
- done and key_valid are never high in the same cycle.

Test Plan:
- Reset then start with round_key_10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, key_ready=1 constant -> keys appear on 11 consecutive cycles:
  - idx 10 = input
  - idx 9 = ac7766f3_19fadc21_28d12941_575c006e
  - idx 0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c
  - done pulses the cycle after the idx-0 transfer; busy falls with it.
- Same stimulus, key_ready toggled pseudo-randomly (including 5-cycle stall at idx 9) -> round_key and round_idx stable during stalls; the same 11-key sequence is delivered in order.
- start pulsed during EMIT at idx 6 with a different round_key_10 -> ignored; sequence completes with the original keys and a single done.
- rst_n asserted at idx 4 mid-schedule -> outputs go to 0 immediately; no done. After release, start with all-zero round_key_10 -> idx 0 key matches the reference-model inverse of all-zero (compare against software model).
- Final transfer at idx 0 followed by start on the done cycle -> new schedule accepted; key 10 of the new schedule is valid the next cycle.
- Random round_key_10 x1000 vs software key-expansion model -> forward-expanding the reported idx-0 key reproduces all 11 keys exactly.
